// File: rtl/lut_layer_if.sv
// Handshake and LUT-bank bus between a folded layer sequencer and its neighbours.
// The slave side is the sequencer; the master side is upstream/downstream logic and the LUT bank.
interface lut_layer_if #(
   parameter int NUM_NEURONS = 16,
   parameter int FAN_IN      = 8
);
   localparam int SEL_W = $clog2(NUM_NEURONS);

   logic                          in_valid;
   logic                          in_ready;
   logic [NUM_NEURONS*FAN_IN-1:0] in_data;
   logic                          lut_en;
   logic [SEL_W-1:0]              lut_sel;
   logic [FAN_IN-1:0]             lut_addr;
   logic                          lut_q;
   logic                          out_valid;
   logic                          out_ready;
   logic [NUM_NEURONS-1:0]        out_data;

   modport master (
      output in_valid, in_data, lut_q, out_ready,
      input  in_ready, lut_en, lut_sel, lut_addr, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, lut_q, out_ready,
      output in_ready, lut_en, lut_sel, lut_addr, out_valid, out_data
   );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Folds one shared neuron LUT bank across a whole layer: one lookup per cycle,
// results gathered into the layer output vector.
//
// state   | meaning
// IDLE    | waiting for an input frame, in_ready high
// ISSUE   | one lookup per cycle, neuron 0..N-1
// DRAIN   | waiting for the last LUT_LAT results to return
// DONE    | output vector valid, held until out_ready
module lut_layer_sequencer #(
   parameter int NUM_NEURONS = 16,
   parameter int FAN_IN      = 8,
   parameter int LUT_LAT     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   lut_layer_if.slave  bus,
   output logic        busy,
   output logic [15:0] frame_cnt
);
   localparam int SEL_W = $clog2(NUM_NEURONS);
   localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_NEURONS - 1);
   localparam logic [1:0]       DRAIN_INIT = 2'(LUT_LAT > 0 ? LUT_LAT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                        state_q;
   logic [NUM_NEURONS*FAN_IN-1:0] frame_q;
   logic                          lut_en_q;
   logic [SEL_W-1:0]              lut_sel_q;
   logic [FAN_IN-1:0]             lut_addr_q;
   logic                          out_valid_q;
   logic [NUM_NEURONS-1:0]        out_data_q;
   logic [15:0]                   frame_cnt_q;
   logic [1:0]                    drain_q;
   logic                          cap_vld;
   logic [SEL_W-1:0]              cap_idx;
   logic [SEL_W-1:0]              sel_nxt;

   assign sel_nxt = lut_sel_q + 1'b1;

   // Tag each lookup with its neuron index so the result lands in the right bit.
   if (LUT_LAT == 0) begin : g_cap_comb
      assign cap_vld = lut_en_q;
      assign cap_idx = lut_sel_q;
   end else begin : g_cap_pipe
      logic [LUT_LAT-1:0] vld_q;
      logic [SEL_W-1:0]   idx_q [LUT_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
            for (int j = 0; j < LUT_LAT; j++) idx_q[j] <= '0;
         end else begin
            vld_q[0] <= lut_en_q;
            idx_q[0] <= lut_sel_q;
            for (int j = 1; j < LUT_LAT; j++) begin
               vld_q[j] <= vld_q[j-1];
               idx_q[j] <= idx_q[j-1];
            end
         end
      end

      assign cap_vld = vld_q[LUT_LAT-1];
      assign cap_idx = idx_q[LUT_LAT-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         frame_q     <= '0;
         lut_en_q    <= 1'b0;
         lut_sel_q   <= '0;
         lut_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         frame_cnt_q <= '0;
         drain_q     <= '0;
      end else begin
         if (cap_vld) out_data_q[cap_idx] <= bus.lut_q;
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  frame_q    <= bus.in_data;
                  lut_en_q   <= 1'b1;
                  lut_sel_q  <= '0;
                  lut_addr_q <= bus.in_data[FAN_IN-1:0];
                  out_data_q <= '0;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (lut_sel_q == LAST_SEL) begin
                  lut_en_q <= 1'b0;
                  drain_q  <= DRAIN_INIT;
                  if (LUT_LAT == 0) begin
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end else begin
                  lut_sel_q  <= sel_nxt;
                  lut_addr_q <= frame_q[sel_nxt*FAN_IN +: FAN_IN];
               end
            end
            S_DRAIN: begin
               if (drain_q == 2'd0) begin
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  drain_q <= drain_q - 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.lut_en    = lut_en_q;
   assign bus.lut_sel   = lut_sel_q;
   assign bus.lut_addr  = lut_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = (state_q != S_IDLE);
   assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Bench for lut_layer_sequencer: three instances (LUT_LAT 1, 0, 3) share stimulus,
// each with its own LUT bank model; results are compared against a layer-level reference.
module tb_lut_layer_sequencer;
   localparam int N = 16;
   localparam int F = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [N*F-1:0] in_data = '0;

   int total = 0;
   int bad = 0;
   logic [15:0] exp_cnt = '0;

   logic [2:0][N-1:0] od;
   logic [2:0]        ov, rdy, ena, bz;
   logic [2:0][31:0]  lat_a;

   for (genvar k = 0; k < 3; k++) begin : g
      localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 0 : 3);

      lut_layer_if #(.NUM_NEURONS(N), .FAN_IN(F)) bus ();
      logic        busy;
      logic [15:0] frame_cnt;

      lut_layer_sequencer #(.NUM_NEURONS(N), .FAN_IN(F), .LUT_LAT(LAT)) dut (
         .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .frame_cnt(frame_cnt)
      );

      assign bus.in_valid  = in_valid;
      assign bus.in_data   = in_data;
      assign bus.out_ready = out_ready;

      // LUT bank: q = parity(addr) ^ sel[0], X whenever no result is due
      if (LAT == 0) begin : g_bank
         assign bus.lut_q = (bus.lut_en === 1'b1) ? (^bus.lut_addr ^ bus.lut_sel[0]) : 1'bx;
      end else begin : g_bank
         logic pv [LAT];
         logic pd [LAT];
         always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int j = 0; j < LAT; j++) begin pv[j] <= 1'b0; pd[j] <= 1'b0; end
            end else begin
               pv[0] <= (bus.lut_en === 1'b1);
               pd[0] <= ^bus.lut_addr ^ bus.lut_sel[0];
               for (int j = 1; j < LAT; j++) begin pv[j] <= pv[j-1]; pd[j] <= pd[j-1]; end
            end
         end
         assign bus.lut_q = pv[LAT-1] ? pd[LAT-1] : 1'bx;
      end

      int unsigned acc_edge = 0;
      int unsigned lat_meas = 0;
      int unsigned en_cnt = 0;
      logic        ov_prev = 1'b0;
      logic [3:0]  sel_log [$];
      logic [7:0]  addr_log [$];

      always @(negedge clk) begin
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_edge = ecnt + 1;
         if (bus.out_valid === 1'b1 && !ov_prev) lat_meas = ecnt - acc_edge;
         ov_prev = (bus.out_valid === 1'b1);
         if (bus.lut_en === 1'b1) begin
            en_cnt++;
            sel_log.push_back(bus.lut_sel);
            addr_log.push_back(bus.lut_addr);
         end
      end

      assign od[k]    = bus.out_data;
      assign ov[k]    = bus.out_valid;
      assign rdy[k]   = bus.in_ready;
      assign ena[k]   = bus.lut_en;
      assign bz[k]    = busy;
      assign lat_a[k] = lat_meas;
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
   endfunction

   function automatic logic [N-1:0] ref_layer(input logic [N*F-1:0] fr);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (^fr[i*F +: F]) ^ (i % 2 == 1);
      return r;
   endfunction

   function automatic logic [N*F-1:0] rnd_frame();
      logic [N*F-1:0] r;
      for (int w = 0; w < N*F/32; w++) r[w*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic send_frame(input logic [N*F-1:0] d);
      int n = 0;
      @(negedge clk);
      while (rdy !== 3'b111 && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int n = 0;
      @(negedge clk);
      while (ov !== 3'b111 && n < 80) begin @(negedge clk); n++; end
      ok = (ov === 3'b111);
      #1;
   endtask

   task automatic pop_out();
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      exp_cnt++;
      @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input logic [N*F-1:0] d);
      bit ok;
      logic [N-1:0] e;
      e = ref_layer(d);
      wait_out(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s_timeout out_valid=%b required=111", tag, ov); end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (od[k] !== e) begin
            bad++; $display("FAIL %s_data inst=%0d got=%h exp=%h", tag, k, od[k], e);
         end
         total++;
         if (lat_a[k] !== 32'(N + lat_of(k))) begin
            bad++; $display("FAIL %s_latency inst=%0d got=%0d exp=%0d", tag, k, lat_a[k], N + lat_of(k));
         end
      end
   endtask

   task automatic check_cnt(input string tag);
      total++;
      if (g[0].frame_cnt !== exp_cnt) begin
         bad++; $display("FAIL %s_frame_cnt got=%h exp=%h", tag, g[0].frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (rdy !== 3'b111) begin bad++; $display("FAIL reset_in_ready got=%b exp=111", rdy); end
      total++;
      if ({ov, ena, bz} !== 9'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {ov, ena, bz}); end
      total++;
      if (od !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", od); end
      total++;
      if ({g[0].bus.lut_sel, g[0].bus.lut_addr} !== 12'h000) begin
         bad++; $display("FAIL reset_sel_addr got=%h exp=000", {g[0].bus.lut_sel, g[0].bus.lut_addr});
      end
      check_cnt("reset");
   endtask

   task automatic test_zero_addr();
      int err = 0;
      g[0].sel_log.delete();
      g[0].addr_log.delete();
      send_frame('0);
      check_frame("zero", '0);
      if (g[0].sel_log.size() != N) err++;
      else for (int i = 0; i < N; i++)
         if (g[0].sel_log[i] !== 4'(i) || g[0].addr_log[i] !== 8'h00) err++;
      total++;
      if (err != 0) begin
         bad++; $display("FAIL zero_sel_seq issues=%0d errors=%0d exp issues=16 errors=0", g[0].sel_log.size(), err);
      end
      pop_out();
      check_cnt("zero");
   endtask

   task automatic test_diag();
      logic [N*F-1:0] d;
      int err = 0;
      for (int i = 0; i < N; i++) d[i*F +: F] = 8'(i * 8'h11);
      g[0].addr_log.delete();
      send_frame(d);
      check_frame("diag", d);
      for (int i = 0; i < N; i++) if (g[0].addr_log[i] !== 8'(i * 8'h11)) err++;
      total++;
      if (err != 0) begin bad++; $display("FAIL diag_addr_seq errors=%0d exp=0", err); end
      pop_out();
      check_cnt("diag");
   endtask

   task automatic test_random();
      logic [N*F-1:0] d;
      for (int f = 0; f < 8; f++) begin
         d = rnd_frame();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send_frame(d);
         check_frame("rand", d);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         total++;
         if (od[0] !== ref_layer(d)) begin
            bad++; $display("FAIL rand_hold got=%h exp=%h", od[0], ref_layer(d));
         end
         pop_out();
         check_cnt("rand");
      end
   endtask

   task automatic test_stall();
      logic [N*F-1:0] d, d2;
      int errs = 0;
      int unsigned en0;
      d  = rnd_frame();
      d2 = rnd_frame();
      send_frame(d);
      check_frame("stall_pre", d);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d2;
      en0 = g[0].en_cnt;
      repeat (50) begin
         @(negedge clk);
         if (od[0] !== ref_layer(d) || ov !== 3'b111 || rdy !== 3'b000) errs++;
      end
      #1;
      total++;
      if (errs != 0) begin bad++; $display("FAIL stall_hold errors=%0d exp=0", errs); end
      total++;
      if (g[0].en_cnt !== en0) begin bad++; $display("FAIL stall_lut_en got=%0d exp=%0d", g[0].en_cnt, en0); end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
      total++;
      if (rdy !== 3'b111 || ov !== 3'b000) begin
         bad++; $display("FAIL stall_release in_ready=%b out_valid=%b exp=111/000", rdy, ov);
      end
      check_cnt("stall");
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      total++;
      if (bz !== 3'b111) begin bad++; $display("FAIL stall_next_accept busy=%b exp=111", bz); end
      check_frame("stall_next", d2);
      pop_out();
      check_cnt("stall_next");
   endtask

   task automatic test_reset_mid();
      logic [N*F-1:0] d;
      int n = 0;
      send_frame(rnd_frame());
      @(negedge clk);
      while (!(ena[0] === 1'b1 && g[0].bus.lut_sel === 4'd7) && n < 40) begin @(negedge clk); n++; end
      total++;
      if (!(ena[0] === 1'b1 && g[0].bus.lut_sel === 4'd7)) begin
         bad++; $display("FAIL midreset_reach_i7 lut_en=%b sel=%0d exp=1/7", ena[0], g[0].bus.lut_sel);
      end
      rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      total++;
      if (ena !== 3'b000 || bz !== 3'b000 || rdy !== 3'b111) begin
         bad++; $display("FAIL midreset_ctrl lut_en=%b busy=%b in_ready=%b exp=000/000/111", ena, bz, rdy);
      end
      total++;
      if (od !== '0) begin bad++; $display("FAIL midreset_out_data got=%h exp=0", od); end
      check_cnt("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d = rnd_frame();
      send_frame(d);
      check_frame("after_reset", d);
      pop_out();
      check_cnt("after_reset");
   endtask

   task automatic test_wrap();
      logic [N*F-1:0] d;
      d = rnd_frame();
      send_frame(d);
      check_frame("wrap", d);
      force g[0].dut.frame_cnt_q = 16'hFFFF;
      #1;
      release g[0].dut.frame_cnt_q;
      exp_cnt = 16'hFFFF;
      pop_out();
      check_cnt("wrap");
      d = rnd_frame();
      send_frame(d);
      check_frame("post_wrap", d);
      pop_out();
      check_cnt("post_wrap");
   endtask

   initial begin
      test_reset();
      test_zero_addr();
      test_diag();
      test_random();
      test_stall();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
